fpga_piano: RTL and testbench

//  8-key single-voice piano for the board top level. Each slide switch is one key of the C4..C5 scale.
//  - FREQ: square wave at the selected note's pitch, drives the buzzer/audio pin.
//  - Led: mirrors the keys that are held.
//  - 4-digit 7-seg: shows the note name and octave.
//  - MODE button: toggles octave (4/5). MODE2 level: sustain.

---
 rtl/piano_pkg.sv | 82 ++++++++
 rtl/piano_tone_gen.sv | 30 +++
 rtl/fpga_piano.sv | 160 ++++++++++++++++
 tb/tb_fpga_piano.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared types, note pitch table and 7-segment glyphs for the fpga_piano board top.
package piano_pkg;

   localparam int unsigned HP_W  = 24;
   localparam int unsigned NKEYS = 8;

   typedef enum logic [3:0] {
      NOTE_NONE = 4'd0,
      NOTE_C4   = 4'd1,
      NOTE_D4   = 4'd2,
      NOTE_E4   = 4'd3,
      NOTE_F4   = 4'd4,
      NOTE_G4   = 4'd5,
      NOTE_A4   = 4'd6,
      NOTE_B4   = 4'd7,
      NOTE_C5   = 4'd8
   } note_t;

   // Active-low cathodes {dp,g,f,e,d,c,b,a}; dp is always off
   localparam logic [7:0] SEG_C     = 8'hC6;
   localparam logic [7:0] SEG_D     = 8'hA1;
   localparam logic [7:0] SEG_E     = 8'h86;
   localparam logic [7:0] SEG_F     = 8'h8E;
   localparam logic [7:0] SEG_G     = 8'hC2;
   localparam logic [7:0] SEG_A     = 8'h88;
   localparam logic [7:0] SEG_B     = 8'h83;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Octave-4 note frequencies in centi-Hz, indexed C4..C5
   function automatic int unsigned note_chz(input logic [2:0] k);
      int unsigned f;
      case (k)
         3'd0:    f = 26163;
         3'd1:    f = 29366;
         3'd2:    f = 32963;
         3'd3:    f = 34923;
         3'd4:    f = 39200;
         3'd5:    f = 44000;
         3'd6:    f = 49388;
         default: f = 52325;
      endcase
      return f;
   endfunction

   function automatic logic [HP_W-1:0] calc_hp(input longint unsigned clk_hz, input logic [2:0] k);
      longint unsigned num;
      longint unsigned den;
      num = clk_hz * 64'd100;
      den = 64'd2 * 64'(note_chz(k));
      return HP_W'(num / den);
   endfunction

   // Highest-index key wins, which is the lowest pitch
   function automatic note_t key_to_note(input logic [NKEYS-1:0] keys);
      note_t n;
      n = NOTE_NONE;
      for (int i = 0; i < NKEYS; i++) begin
         if (keys[i]) n = note_t'(4'(NKEYS - i));
      end
      return n;
   endfunction

   function automatic logic [7:0] letter_glyph(input note_t n);
      logic [7:0] g;
      case (n)
         NOTE_C4, NOTE_C5: g = SEG_C;
         NOTE_D4:          g = SEG_D;
         NOTE_E4:          g = SEG_E;
         NOTE_F4:          g = SEG_F;
         NOTE_G4:          g = SEG_G;
         NOTE_A4:          g = SEG_A;
         NOTE_B4:          g = SEG_B;
         default:          g = SEG_DASH;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/piano_tone_gen.sv
// Square-wave generator: FREQ toggles every hp clocks; restart/disable clear the phase.
module piano_tone_gen
   import piano_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [HP_W-1:0] hp,
   input  logic            enable,
   input  logic            restart,
   output logic            freq
);

   logic [HP_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         freq <= 1'b0;
      end else if (!enable || restart) begin
         cnt  <= '0;
         freq <= 1'b0;
      end else if (cnt == hp - HP_W'(1)) begin
         cnt  <= '0;
         freq <= ~freq;
      end else begin
         cnt <= cnt + HP_W'(1);
      end
   end

endmodule

// File: rtl/fpga_piano.sv
// 8-key single-voice piano: key select, octave toggle, sustain, tone and 7-seg note display.
// Optional MODE debounce filter is enabled with `define PIANO_DEBOUNCE_EN.
module fpga_piano
   import piano_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned REFRESH_DIV  = 2**16
`ifdef PIANO_DEBOUNCE_EN
   ,
   parameter int unsigned DEBOUNCE_CYC = 2**20
`endif
)
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             MODE,
   input  logic             MODE2,
   input  logic [NKEYS-1:0] sw,
   output logic             FREQ,
   output logic [NKEYS-1:0] Led,
   output logic [7:0]       seg,
   output logic [3:0]       an
);

   localparam longint unsigned CLK_HZ64 = 64'(CLK_HZ);
   localparam int unsigned     RF_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [HP_W-1:0] HP_TAB [NKEYS] = '{
      calc_hp(CLK_HZ64, 3'd0), calc_hp(CLK_HZ64, 3'd1),
      calc_hp(CLK_HZ64, 3'd2), calc_hp(CLK_HZ64, 3'd3),
      calc_hp(CLK_HZ64, 3'd4), calc_hp(CLK_HZ64, 3'd5),
      calc_hp(CLK_HZ64, 3'd6), calc_hp(CLK_HZ64, 3'd7)
   };

   logic [NKEYS-1:0] sw_s1;
   logic             mode_s1, mode_s2;
   logic             mode2_s1, mode2_s2;
   logic             mode_acc, mode_prev;
   logic             octave, oct_nxt;
   note_t            note, note_nxt, key_note;
   logic             restart, tone_en;
   logic [2:0]       note_idx;
   logic [HP_W-1:0]  hp_base, hp;
   logic [RF_W-1:0]  dcnt;
   logic [1:0]       slot;
   logic [7:0]       dig0, dig1;

   // Two-flop synchronizers; the second sw stage doubles as the Led mirror
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sw_s1    <= '0;
         Led      <= '0;
         mode_s1  <= 1'b0;
         mode_s2  <= 1'b0;
         mode2_s1 <= 1'b0;
         mode2_s2 <= 1'b0;
      end else begin
         sw_s1    <= sw;
         Led      <= sw_s1;
         mode_s1  <= MODE;
         mode_s2  <= mode_s1;
         mode2_s1 <= MODE2;
         mode2_s2 <= mode2_s1;
      end
   end

`ifdef PIANO_DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

   logic [DB_W-1:0] db_cnt;
   logic            mode_db;

   // A new MODE level is accepted only after DEBOUNCE_CYC consecutive clocks
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         db_cnt  <= '0;
         mode_db <= 1'b0;
      end else if (mode_s2 == mode_db) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
         db_cnt  <= '0;
         mode_db <= mode_s2;
      end else begin
         db_cnt <= db_cnt + DB_W'(1);
      end
   end

   assign mode_acc = mode_db;
`else
   assign mode_acc = mode_s2;
`endif

   // Next note/octave; restart is raised on the same edge the new pitch is loaded
   always_comb begin
      key_note = key_to_note(Led);
      note_nxt = key_note;
      if (key_note == NOTE_NONE && mode2_s2) note_nxt = note;
      oct_nxt  = octave ^ (mode_acc & ~mode_prev);
      restart  = (note_nxt != note) || (oct_nxt != octave);
      tone_en  = (note_nxt != NOTE_NONE);
      note_idx = 3'(note - NOTE_C4);
      hp_base  = HP_TAB[note_idx];
      hp       = octave ? (hp_base >> 1) : hp_base;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         note      <= NOTE_NONE;
         octave    <= 1'b0;
         mode_prev <= 1'b0;
      end else begin
         note      <= note_nxt;
         octave    <= oct_nxt;
         mode_prev <= mode_acc;
      end
   end

   piano_tone_gen u_tone (
      .clk     (CLK),
      .rst     (RESET),
      .hp      (hp),
      .enable  (tone_en),
      .restart (restart),
      .freq    (FREQ)
   );

   always_comb begin
      dig0 = SEG_DASH;
      dig1 = SEG_DASH;
      if (note != NOTE_NONE) begin
         dig0 = letter_glyph(note);
         if (note == NOTE_C5) dig1 = octave ? SEG_6 : SEG_5;
         else                 dig1 = octave ? SEG_5 : SEG_4;
      end
   end

   // Digit scan: each slot is driven for REFRESH_DIV clocks
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dcnt <= '0;
         slot <= 2'd0;
         an   <= 4'hF;
         seg  <= SEG_BLANK;
      end else begin
         an <= ~(4'b0001 << slot);
         case (slot)
            2'd0:    seg <= dig0;
            2'd1:    seg <= dig1;
            default: seg <= SEG_BLANK;
         endcase
         if (dcnt == RF_W'(REFRESH_DIV - 1)) begin
            dcnt <= '0;
            slot <= slot + 2'd1;
         end else begin
            dcnt <= dcnt + RF_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fpga_piano.sv
// Directed self-checking bench for fpga_piano at a reduced clock rate (CLK_HZ = 250 kHz).
module tb_fpga_piano;
   import piano_pkg::*;

   logic       CLK   = 1'b0;
   logic       RESET = 1'b1;
   logic       MODE  = 1'b0;
   logic       MODE2 = 1'b0;
   logic [7:0] sw    = 8'h00;
   logic       FREQ;
   logic [7:0] Led;
   logic [7:0] seg;
   logic [3:0] an;

   int checks = 0;
   int errors = 0;

   fpga_piano #(
      .CLK_HZ      (250_000),
      .REFRESH_DIV (4)
`ifdef PIANO_DEBOUNCE_EN
      ,
      .DEBOUNCE_CYC(16)
`endif
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .MODE  (MODE),
      .MODE2 (MODE2),
      .sw    (sw),
      .FREQ  (FREQ),
      .Led   (Led),
      .seg   (seg),
      .an    (an)
   );

   always #5 CLK = ~CLK;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Lengths of one full high phase and the following low phase
   task automatic measure(output int hi, output int lo);
      int guard;
      hi = 0;
      lo = 0;
      guard = 0;
      while (FREQ === 1'b1 && guard < 2000) begin guard++; tick(1); end
      guard = 0;
      while (FREQ !== 1'b1 && guard < 2000) begin guard++; tick(1); end
      if (FREQ === 1'b1) begin
         while (FREQ === 1'b1 && hi < 2000) begin hi++; tick(1); end
         while (FREQ === 1'b0 && lo < 2000) begin lo++; tick(1); end
      end
   endtask

   task automatic get_digit(input int d, output logic [7:0] s);
      logic [3:0] want;
      bit         found;
      want  = ~(4'b0001 << d);
      s     = 'x;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!found && an === want) begin
            s     = seg;
            found = 1'b1;
         end
         if (!found) tick(1);
      end
   endtask

   task automatic wait_high();
      int guard;
      guard = 0;
      while (FREQ !== 1'b1 && guard < 2000) begin guard++; tick(1); end
   endtask

   task automatic test_reset();
      logic [3:0] exp_an  [4];
      logic [7:0] exp_seg [4];
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{8'hBF, 8'hBF, 8'hFF, 8'hFF};
      RESET = 1'b1;
      tick(3);
      checks++; if (FREQ !== 1'b0) begin errors++; $display("FAIL rst_freq: got %b expected 0", FREQ); end
      checks++; if (Led !== 8'h00) begin errors++; $display("FAIL rst_led: got %h expected 00", Led); end
      checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL rst_seg: got %h expected ff", seg); end
      checks++; if (an !== 4'hF)   begin errors++; $display("FAIL rst_an: got %b expected 1111", an); end
      RESET = 1'b0;
      tick(1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (an !== exp_an[k]) begin errors++; $display("FAIL scan_an%0d: got %b expected %b", k, an, exp_an[k]); end
         checks++;
         if (seg !== exp_seg[k]) begin errors++; $display("FAIL scan_seg%0d: got %h expected %h", k, seg, exp_seg[k]); end
         tick(4);
      end
      checks++; if (an !== 4'b1110) begin errors++; $display("FAIL scan_wrap: got %b expected 1110", an); end
      checks++; if (FREQ !== 1'b0) begin errors++; $display("FAIL idle_freq: got %b expected 0", FREQ); end
   endtask

   task automatic test_e4();
      int hi, lo;
      logic [7:0] s;
      logic [23:0] hp100;
      sw = 8'h20;
      tick(6);
      checks++; if (Led !== 8'h20) begin errors++; $display("FAIL e4_led: got %h expected 20", Led); end
      measure(hi, lo);
      checks++; if (hi !== 379) begin errors++; $display("FAIL e4_high: got %0d expected 379", hi); end
      checks++; if (lo !== 379) begin errors++; $display("FAIL e4_low: got %0d expected 379", lo); end
      get_digit(0, s);
      checks++; if (s !== 8'h86) begin errors++; $display("FAIL e4_digit0: got %h expected 86", s); end
      get_digit(1, s);
      checks++; if (s !== 8'h99) begin errors++; $display("FAIL e4_digit1: got %h expected 99", s); end
      hp100 = calc_hp(64'd100_000_000, 3'd2);
      checks++; if (hp100 !== 24'd151685) begin errors++; $display("FAIL e4_hp100m: got %0d expected 151685", hp100); end
   endtask

   task automatic test_priority();
      int hi, lo;
      logic [7:0] s;
      sw = 8'h88;
      tick(6);
      checks++; if (Led !== 8'h88) begin errors++; $display("FAIL prio_led: got %h expected 88", Led); end
      measure(hi, lo);
      checks++; if (hi !== 477) begin errors++; $display("FAIL prio_high: got %0d expected 477", hi); end
      checks++; if (lo !== 477) begin errors++; $display("FAIL prio_low: got %0d expected 477", lo); end
      get_digit(0, s);
      checks++; if (s !== 8'hC6) begin errors++; $display("FAIL prio_digit0: got %h expected c6", s); end
   endtask

   task automatic test_release();
      int hi, lo;
      logic [7:0] s;
      wait_high();
      sw = 8'h00;
      tick(3);
      checks++; if (FREQ !== 1'b0) begin errors++; $display("FAIL rel_freq: got %b expected 0", FREQ); end
      tick(3);
      checks++; if (Led !== 8'h00) begin errors++; $display("FAIL rel_led: got %h expected 00", Led); end
      get_digit(0, s);
      checks++; if (s !== 8'hBF) begin errors++; $display("FAIL rel_digit0: got %h expected bf", s); end
      MODE2 = 1'b1;
      sw = 8'h20;
      tick(8);
      wait_high();
      sw = 8'h00;
      tick(6);
      measure(hi, lo);
      checks++; if (hi !== 379) begin errors++; $display("FAIL sus_high: got %0d expected 379", hi); end
      checks++; if (lo !== 379) begin errors++; $display("FAIL sus_low: got %0d expected 379", lo); end
      get_digit(0, s);
      checks++; if (s !== 8'h86) begin errors++; $display("FAIL sus_digit0: got %h expected 86", s); end
      wait_high();
      MODE2 = 1'b0;
      tick(3);
      checks++; if (FREQ !== 1'b0) begin errors++; $display("FAIL sus_off_freq: got %b expected 0", FREQ); end
   endtask

   task automatic test_octave();
      int hi, lo;
      logic [7:0] s;
      logic [23:0] hp100;
      sw = 8'h00;
      tick(6);
`ifdef PIANO_DEBOUNCE_EN
      repeat (5) begin MODE = 1'b1; tick(1); MODE = 1'b0; tick(2); end
      sw = 8'h04;
      tick(6);
      measure(hi, lo);
      checks++; if (hi !== 284) begin errors++; $display("FAIL glitch_high: got %0d expected 284", hi); end
      MODE = 1'b1;
      tick(40);
      MODE = 1'b0;
      tick(40);
`else
      repeat (4) begin MODE = 1'b1; tick(1); MODE = 1'b0; tick(2); end
      sw = 8'h04;
      tick(6);
      measure(hi, lo);
      checks++; if (hi !== 284) begin errors++; $display("FAIL oct4_high: got %0d expected 284", hi); end
      MODE = 1'b1; tick(1); MODE = 1'b0;
      tick(6);
`endif
      measure(hi, lo);
      checks++; if (hi !== 142) begin errors++; $display("FAIL oct5_high: got %0d expected 142", hi); end
      checks++; if (lo !== 142) begin errors++; $display("FAIL oct5_low: got %0d expected 142", lo); end
      get_digit(0, s);
      checks++; if (s !== 8'h88) begin errors++; $display("FAIL oct5_digit0: got %h expected 88", s); end
      get_digit(1, s);
      checks++; if (s !== 8'h92) begin errors++; $display("FAIL oct5_digit1: got %h expected 92", s); end
      sw = 8'h01;
      tick(6);
      measure(hi, lo);
      checks++; if (hi !== 119) begin errors++; $display("FAIL c6_high: got %0d expected 119", hi); end
      get_digit(1, s);
      checks++; if (s !== 8'h82) begin errors++; $display("FAIL c6_digit1: got %h expected 82", s); end
      hp100 = calc_hp(64'd100_000_000, 3'd5) >> 1;
      checks++; if (hp100 !== 24'd56818) begin errors++; $display("FAIL a5_hp100m: got %0d expected 56818", hp100); end
   endtask

   task automatic test_back_to_back();
      int lo0, hi0;
      int exp_hp;
      logic [7:0] s;
      logic [7:0] exp_d1;
      wait_high();
`ifdef PIANO_DEBOUNCE_EN
      exp_hp = 142;
      exp_d1 = 8'h92;
      sw = 8'h04;
      tick(3);
`else
      exp_hp = 284;
      exp_d1 = 8'h99;
      MODE = 1'b1;
      sw = 8'h04;
      tick(1);
      MODE = 1'b0;
      tick(2);
`endif
      checks++; if (FREQ !== 1'b0) begin errors++; $display("FAIL b2b_restart: got %b expected 0", FREQ); end
      lo0 = 0;
      while (FREQ === 1'b0 && lo0 < 2000) begin lo0++; tick(1); end
      hi0 = 0;
      while (FREQ === 1'b1 && hi0 < 2000) begin hi0++; tick(1); end
      checks++; if (lo0 !== exp_hp) begin errors++; $display("FAIL b2b_first_low: got %0d expected %0d", lo0, exp_hp); end
      checks++; if (hi0 !== exp_hp) begin errors++; $display("FAIL b2b_first_high: got %0d expected %0d", hi0, exp_hp); end
      get_digit(1, s);
      checks++; if (s !== exp_d1) begin errors++; $display("FAIL b2b_digit1: got %h expected %h", s, exp_d1); end
   endtask

   initial begin
      test_reset();
      test_e4();
      test_priority();
      test_release();
      test_octave();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
